// File: rtl/res_arb_pkg.sv
// Shared constants and port encoding for the result-RAM arbiter.
package res_arb_pkg;

    localparam int unsigned AW_DEF       = 14;
    localparam int unsigned DW_DEF       = 8;
    localparam int unsigned MAX_LOCK_DEF = 64;

    typedef enum logic [1:0] {
        PORT_NONE = 2'b00,
        PORT_A    = 2'b01,
        PORT_B    = 2'b10
    } port_e;

endpackage

// File: rtl/res_ram_arbiter_if.sv
// Requester A/B handshakes plus the result-RAM strobes, as seen by the arbiter.
interface res_ram_arbiter_if
    import res_arb_pkg::*;
#(
    parameter int unsigned AW = AW_DEF,
    parameter int unsigned DW = DW_DEF
);
    logic          a_req, a_wr, a_lock, a_gnt, a_rvalid;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_wdata, a_rdata;
    logic          b_req, b_wr, b_lock, b_gnt, b_rvalid;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_wdata, b_rdata;
    logic          res_rd, res_wr;
    logic [AW-1:0] res_addr;
    logic [DW-1:0] res_do, res_di;

    modport slave (
        input  a_req, a_wr, a_lock, a_addr, a_wdata,
        input  b_req, b_wr, b_lock, b_addr, b_wdata,
        input  res_di,
        output a_gnt, a_rvalid, a_rdata,
        output b_gnt, b_rvalid, b_rdata,
        output res_rd, res_wr, res_addr, res_do
    );

    modport master (
        output a_req, a_wr, a_lock, a_addr, a_wdata,
        output b_req, b_wr, b_lock, b_addr, b_wdata,
        output res_di,
        input  a_gnt, a_rvalid, a_rdata,
        input  b_gnt, b_rvalid, b_rdata,
        input  res_rd, res_wr, res_addr, res_do
    );
endinterface

// File: rtl/res_arb_pick.sv
// Combinational winner select: locked owner first, then lone requester, then priority pointer.
module res_arb_pick
    import res_arb_pkg::*;
#(
    parameter int unsigned MAX_LOCK = MAX_LOCK_DEF,
    localparam int unsigned CW      = $clog2(MAX_LOCK + 1)
) (
    input  logic          a_req_i,
    input  logic          a_lock_i,
    input  logic          b_req_i,
    input  logic          b_lock_i,
    input  port_e         prio_i,
    input  port_e         owner_i,
    input  logic [CW-1:0] lock_cnt_i,
    output port_e         win_c_o
);

    logic budget_ok;

    always_comb begin
        win_c_o   = PORT_NONE;
        budget_ok = (lock_cnt_i < CW'(MAX_LOCK));
        if (owner_i == PORT_A && a_req_i && a_lock_i && budget_ok) begin
            win_c_o = PORT_A;
        end else if (owner_i == PORT_B && b_req_i && b_lock_i && budget_ok) begin
            win_c_o = PORT_B;
        end else if (a_req_i && !b_req_i) begin
            win_c_o = PORT_A;
        end else if (b_req_i && !a_req_i) begin
            win_c_o = PORT_B;
        end else if (a_req_i && b_req_i) begin
            // an exhausted owner always has the pointer aimed at the other port
            win_c_o = (prio_i == PORT_B) ? PORT_B : PORT_A;
        end
    end

endmodule

// File: rtl/res_ram_arbiter.sv
// Two-port arbiter in front of the single-port result RAM with registered read return.
module res_ram_arbiter
    import res_arb_pkg::*;
#(
    parameter int unsigned AW       = AW_DEF,
    parameter int unsigned DW       = DW_DEF,
    parameter int unsigned MAX_LOCK = MAX_LOCK_DEF
) (
    input  logic              clk,
    input  logic              reset,
    res_ram_arbiter_if.slave  bus
);

    localparam int unsigned CW = $clog2(MAX_LOCK + 1);

    port_e         prio_q, prio_d, owner_q, owner_d, win, win_g;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          a_rvalid_q, a_rvalid_d, b_rvalid_q, b_rvalid_d;
    logic [DW-1:0] a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
    logic          gnt_a, gnt_b;
    logic [AW-1:0] addr_c;

    res_arb_pick #(.MAX_LOCK(MAX_LOCK)) u_pick (
        .a_req_i    (bus.a_req),
        .a_lock_i   (bus.a_lock),
        .b_req_i    (bus.b_req),
        .b_lock_i   (bus.b_lock),
        .prio_i     (prio_q),
        .owner_i    (owner_q),
        .lock_cnt_i (cnt_q),
        .win_c_o    (win)
    );

    // Grant and RAM mux; everything is forced idle while reset is held low.
    always_comb begin
        win_g  = reset ? win : PORT_NONE;
        gnt_a  = (win_g == PORT_A);
        gnt_b  = (win_g == PORT_B);
        addr_c = '0;
        if (gnt_a)      addr_c = bus.a_addr;
        else if (gnt_b) addr_c = bus.b_addr;
        bus.a_gnt    = gnt_a;
        bus.b_gnt    = gnt_b;
        bus.res_addr = addr_c;
        bus.res_do   = gnt_a ? bus.a_wdata : (gnt_b ? bus.b_wdata : '0);
        bus.res_wr   = (gnt_a & bus.a_wr) | (gnt_b & bus.b_wr);
        bus.res_rd   = (gnt_a & ~bus.a_wr) | (gnt_b & ~bus.b_wr);
    end

    // Next state: pointer, burst owner, lock budget and read return.
    always_comb begin
        prio_d     = prio_q;
        owner_d    = owner_q;
        cnt_d      = cnt_q;
        a_rvalid_d = gnt_a & ~bus.a_wr;
        b_rvalid_d = gnt_b & ~bus.b_wr;
        a_rdata_d  = a_rvalid_d ? bus.res_di : a_rdata_q;
        b_rdata_d  = b_rvalid_d ? bus.res_di : b_rdata_q;
        if (gnt_a) begin
            prio_d  = PORT_B;
            owner_d = bus.a_lock ? PORT_A : PORT_NONE;
            cnt_d   = (bus.a_lock && bus.b_req)
                    ? ((owner_q == PORT_A) ? cnt_q : '0) + CW'(1) : '0;
        end else if (gnt_b) begin
            prio_d  = PORT_A;
            owner_d = bus.b_lock ? PORT_B : PORT_NONE;
            cnt_d   = (bus.b_lock && bus.a_req)
                    ? ((owner_q == PORT_B) ? cnt_q : '0) + CW'(1) : '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prio_q     <= PORT_A;
            owner_q    <= PORT_NONE;
            cnt_q      <= '0;
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
            a_rdata_q  <= '0;
            b_rdata_q  <= '0;
        end else begin
            prio_q     <= prio_d;
            owner_q    <= owner_d;
            cnt_q      <= cnt_d;
            a_rvalid_q <= a_rvalid_d;
            b_rvalid_q <= b_rvalid_d;
            a_rdata_q  <= a_rdata_d;
            b_rdata_q  <= b_rdata_d;
        end
    end

    assign bus.a_rvalid = a_rvalid_q;
    assign bus.b_rvalid = b_rvalid_q;
    assign bus.a_rdata  = a_rdata_q;
    assign bus.b_rdata  = b_rdata_q;

endmodule
